// File: rtl/apb_mem_slave_if.sv
// APB4 completer-side bundle for apb_mem_slave: bridge drives the request,
// the slave returns read data and the completion/error response.
interface apb_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB4 slave that turns each transfer into one command for a byte-laned
// synchronous memory, with optional wait states and 1-cycle read latency.
//
// state  | meaning
// IDLE   | waiting for a setup phase
// WAIT   | counting down inserted wait states
// CMD    | memory strobe is on the bus (or error skips it)
// RDATA  | memory read data arrives, captured into prdata
// RESP   | pready high, pslverr reflects the latched error
module apb_mem_slave #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_WIDTH      = 8,
  parameter int MEM_SIZE       = 1024,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int WAIT_STATES    = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  apb_mem_slave_if.slave                     apb,
  output logic                               mem_wr,
  output logic                               mem_rd,
  output logic [DATA_WIDTH/MEM_WIDTH-1:0]    mem_be,
  output logic [MEM_ADDR_WIDTH-1:0]          mem_address,
  output logic [DATA_WIDTH-1:0]              mem_data_in,
  input  logic [DATA_WIDTH-1:0]              mem_data_out
);
  localparam int LANES = DATA_WIDTH / MEM_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE * BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CMD, S_RDATA, S_RESP} state_t;

  state_t                    state_q;
  logic [3:0]                cnt_q;
  logic                      write_q;
  logic                      err_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [LANES-1:0]          strb_q;

  logic [DATA_WIDTH-1:0]     prdata_q;
  logic                      pready_q;
  logic                      pslverr_q;
  logic                      mem_wr_q;
  logic                      mem_rd_q;
  logic [LANES-1:0]          mem_be_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0]     mem_data_in_q;

  logic                      setup;
  logic                      setup_err;
  logic [MEM_ADDR_WIDTH-1:0] setup_addr;

  logic                      issue;
  logic                      cmd_write;
  logic                      cmd_err;
  logic [MEM_ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic [LANES-1:0]          cmd_strb;

  assign setup      = apb.psel && !apb.penable;
  assign setup_err  = ((apb.paddr & ALIGN_MASK) != '0) || ({1'b0, apb.paddr} >= ADDR_LIMIT);
  assign setup_addr = MEM_ADDR_WIDTH'(apb.paddr >> LSB);

  // With no wait states the command issues straight from the setup fields,
  // so the outputs can be registered on the same edge that latches them.
  always_comb begin
    cmd_write = write_q;
    cmd_err   = err_q;
    cmd_addr  = addr_q;
    cmd_wdata = wdata_q;
    cmd_strb  = strb_q;
    issue     = 1'b0;
    if (state_q == S_IDLE) begin
      cmd_write = apb.pwrite;
      cmd_err   = setup_err;
      cmd_addr  = setup_addr;
      cmd_wdata = apb.pwdata;
      cmd_strb  = apb.pstrb;
      issue     = setup && (WAIT_STATES == 0);
    end else if (state_q == S_WAIT) begin
      issue     = apb.psel && (cnt_q <= 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      err_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      prdata_q      <= '0;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_be_q      <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      mem_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_be_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;

      if (issue && !cmd_err) begin
        mem_wr_q      <= cmd_write;
        mem_rd_q      <= !cmd_write;
        mem_be_q      <= cmd_write ? cmd_strb : {LANES{1'b1}};
        mem_address_q <= cmd_addr;
        if (cmd_write) begin
          mem_data_in_q <= cmd_wdata;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (setup) begin
            write_q <= apb.pwrite;
            err_q   <= setup_err;
            addr_q  <= setup_addr;
            wdata_q <= apb.pwdata;
            strb_q  <= apb.pstrb;
            cnt_q   <= WAIT_LOAD;
            state_q <= (WAIT_STATES > 0) ? S_WAIT : S_CMD;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (!apb.psel) begin
            state_q <= S_IDLE;
          end else if (cnt_q <= 4'd1) begin
            state_q <= S_CMD;
          end
        end
        S_CMD: begin
          if (!apb.psel) begin
            state_q <= S_IDLE;
          end else if (err_q || write_q) begin
            state_q   <= S_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= err_q;
            prdata_q  <= '0;
          end else begin
            state_q <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (!apb.psel) begin
            state_q <= S_IDLE;
          end else begin
            state_q  <= S_RESP;
            pready_q <= 1'b1;
            prdata_q <= mem_data_out;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign mem_wr      = mem_wr_q;
  assign mem_rd      = mem_rd_q;
  assign mem_be      = mem_be_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two instances (0 and 3 wait states) on a shared
// APB master, each backed by a byte-laned registered-read memory model.
module tb_apb_mem_slave;
  localparam int AW = 32, DW = 32, LANES = 4, MAW = 10, MSZ = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             psel, penable, pwrite, use3;
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata;
  logic [LANES-1:0] pstrb;

  apb_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(LANES)) if0 ();
  apb_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(LANES)) if3 ();

  assign if0.psel = psel && !use3;  assign if3.psel = psel && use3;
  assign if0.penable = penable;     assign if3.penable = penable;
  assign if0.pwrite = pwrite;       assign if3.pwrite = pwrite;
  assign if0.paddr = paddr;         assign if3.paddr = paddr;
  assign if0.pwdata = pwdata;       assign if3.pwdata = pwdata;
  assign if0.pstrb = pstrb;         assign if3.pstrb = pstrb;

  logic m0_wr, m0_rd, m3_wr, m3_rd;
  logic [LANES-1:0] m0_be, m3_be;
  logic [MAW-1:0]   m0_addr, m3_addr;
  logic [DW-1:0]    m0_din, m3_din, m0_dout, m3_dout;

  apb_mem_slave #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .apb(if0), .mem_wr(m0_wr), .mem_rd(m0_rd), .mem_be(m0_be),
    .mem_address(m0_addr), .mem_data_in(m0_din), .mem_data_out(m0_dout));
  apb_mem_slave #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .apb(if3), .mem_wr(m3_wr), .mem_rd(m3_rd), .mem_be(m3_be),
    .mem_address(m3_addr), .mem_data_in(m3_din), .mem_data_out(m3_dout));

  logic [DW-1:0] mem0 [MSZ];
  logic [DW-1:0] mem3 [MSZ];

  always @(posedge clk) begin
    m0_dout <= '0;
    m3_dout <= '0;
    for (int l = 0; l < LANES; l++) begin
      if (m0_wr && m0_be[l]) mem0[m0_addr][l*8 +: 8] <= m0_din[l*8 +: 8];
      if (m0_rd && m0_be[l]) m0_dout[l*8 +: 8] <= mem0[m0_addr][l*8 +: 8];
      if (m3_wr && m3_be[l]) mem3[m3_addr][l*8 +: 8] <= m3_din[l*8 +: 8];
      if (m3_rd && m3_be[l]) m3_dout[l*8 +: 8] <= mem3[m3_addr][l*8 +: 8];
    end
  end

  // Strobe/response monitor, sampled mid-cycle.
  int wr_n0 = 0, rd_n0 = 0, rdy_n0 = 0, wr_n3 = 0, rd_n3 = 0, rdy_n3 = 0;
  logic [LANES-1:0] be_seen;
  logic [MAW-1:0]   addr_seen;
  always @(negedge clk) begin
    if (m0_wr) wr_n0++;
    if (m0_rd) rd_n0++;
    if (if0.pready) rdy_n0++;
    if (m3_wr) wr_n3++;
    if (m3_rd) rd_n3++;
    if (if3.pready) rdy_n3++;
    if (!use3 && (m0_wr || m0_rd)) begin be_seen = m0_be; addr_seen = m0_addr; end
    if (use3 && (m3_wr || m3_rd))  begin be_seen = m3_be; addr_seen = m3_addr; end
  end

  logic          cur_pready, cur_pslverr;
  logic [DW-1:0] cur_prdata;
  assign cur_pready  = use3 ? if3.pready  : if0.pready;
  assign cur_pslverr = use3 ? if3.pslverr : if0.pslverr;
  assign cur_prdata  = use3 ? if3.prdata  : if0.prdata;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, " prdata"}, if0.prdata, 0);
    chk({tag, " pready"}, 32'(if0.pready), 0);
    chk({tag, " pslverr"}, 32'(if0.pslverr), 0);
    chk({tag, " mem_wr"}, 32'(m0_wr), 0);
    chk({tag, " mem_rd"}, 32'(m0_rd), 0);
    chk({tag, " mem_be"}, 32'(m0_be), 0);
    chk({tag, " mem_address"}, 32'(m0_addr), 0);
    chk({tag, " mem_data_in"}, m0_din, 0);
  endtask

  typedef struct {
    bit               dut3;
    bit               wr;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata;
    logic [LANES-1:0] strb;
    logic [DW-1:0]    exp_rdata;
    logic [DW-1:0]    alt_rdata;
    bit               exp_err;
    int               exp_lat;
    int               exp_wr;
    int               exp_rd;
    logic [LANES-1:0] exp_be;
    logic [MAW-1:0]   exp_maddr;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [DW-1:0] alt;
    bit            err;
    int            lat;
  } exp_t;
  exp_t sb[$];

  function automatic vec_t mk(bit d3, bit wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] strb, logic [31:0] rdata, bit err, int lat,
                              int nwr, int nrd, logic [3:0] be, logic [9:0] maddr);
    vec_t v;
    v = '{d3, wr, addr, wdata, strb, rdata, rdata, err, lat, nwr, nrd, be, maddr};
    return v;
  endfunction

  // Called at posedge+1; leaves the bus idle at posedge+1 after completion,
  // so consecutive calls exercise back-to-back transfers.
  task automatic xfer(input string tag, input vec_t v);
    exp_t e;
    int   cyc, w_start, r_start;
    bit   seen;
    use3    = v.dut3;
    w_start = v.dut3 ? wr_n3 : wr_n0;
    r_start = v.dut3 ? rd_n3 : rd_n0;
    sb.push_back('{v.exp_rdata, v.alt_rdata, v.exp_err, v.exp_lat});
    psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr; pwdata = v.wdata; pstrb = v.strb;
    @(posedge clk); #1 penable = 1'b1;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 30) begin
      @(negedge clk);
      if (cur_pready) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s timeout: no pready within %0d cycles", tag, cyc);
    end else begin
      chk({tag, " latency"}, 32'(cyc), 32'(e.lat));
      checks++;
      if (cur_prdata !== e.rdata && cur_prdata !== e.alt) begin
        failures++;
        $display("FAIL %s prdata: got 0x%0h expected 0x%0h or 0x%0h", tag, cur_prdata, e.rdata, e.alt);
      end
      chk({tag, " pslverr"}, 32'(cur_pslverr), 32'(e.err));
      chk({tag, " mem_wr cycles"}, 32'((v.dut3 ? wr_n3 : wr_n0) - w_start), 32'(v.exp_wr));
      chk({tag, " mem_rd cycles"}, 32'((v.dut3 ? rd_n3 : rd_n0) - r_start), 32'(v.exp_rd));
      if (v.exp_wr + v.exp_rd > 0) begin
        chk({tag, " mem_be"}, 32'(be_seen), 32'(v.exp_be));
        chk({tag, " mem_address"}, 32'(addr_seen), 32'(v.exp_maddr));
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  vec_t vecs[14];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w_s, r_s, rdy_s;
    vecs[0]  = mk(0, 1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        0, 2, 1, 0, 4'hF, 10'd4);
    vecs[1]  = mk(0, 0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 0, 3, 0, 1, 4'hF, 10'd4);
    vecs[2]  = mk(0, 0, 32'h1000, 32'h0,        4'h0, 32'h0,        1, 2, 0, 0, 4'h0, 10'd0);
    vecs[3]  = mk(0, 1, 32'h20,   32'h11223344, 4'hF, 32'h0,        0, 2, 1, 0, 4'hF, 10'd8);
    vecs[4]  = mk(0, 1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        0, 2, 1, 0, 4'h5, 10'd8);
    vecs[5]  = mk(0, 0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 0, 3, 0, 1, 4'hF, 10'd8);
    vecs[6]  = mk(0, 0, 32'h1002, 32'h0,        4'h0, 32'h0,        1, 2, 0, 0, 4'h0, 10'd0);
    vecs[7]  = mk(0, 1, 32'h20,   32'hFFFFFFFF, 4'h0, 32'h0,        0, 2, 1, 0, 4'h0, 10'd8);
    vecs[8]  = mk(0, 0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 0, 3, 0, 1, 4'hF, 10'd8);
    vecs[9]  = mk(0, 1, 32'h22,   32'h01020304, 4'hF, 32'h0,        1, 2, 0, 0, 4'h0, 10'd0);
    vecs[10] = mk(0, 1, 32'hFFC,  32'h0BADF00D, 4'hF, 32'h0,        0, 2, 1, 0, 4'hF, 10'h3FF);
    vecs[11] = mk(0, 0, 32'hFFC,  32'h0,        4'h0, 32'h0BADF00D, 0, 3, 0, 1, 4'hF, 10'h3FF);
    vecs[12] = mk(1, 1, 32'h0,    32'h12345678, 4'hF, 32'h0,        0, 5, 1, 0, 4'hF, 10'd0);
    vecs[13] = mk(1, 0, 32'h0,    32'h0,        4'h0, 32'h12345678, 0, 6, 0, 1, 4'hF, 10'd0);

    rst_n = 1'b0; use3 = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge clk);
    #1 chk_zero0("reset");
    chk("reset dut3 pready", 32'(if3.pready), 0);
    chk("reset dut3 mem_rd", 32'(m3_rd), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) xfer($sformatf("v%0d", i), vecs[i]);

    // penable with no setup phase must be ignored
    use3 = 1'b0;
    w_s = wr_n0; r_s = rd_n0; rdy_s = rdy_n0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    repeat (4) @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("noset pready", 32'(rdy_n0 - rdy_s), 0);
    chk("noset mem_wr", 32'(wr_n0 - w_s), 0);
    chk("noset mem_rd", 32'(rd_n0 - r_s), 0);

    // psel dropped while the 3-wait-state read sits in WAIT
    use3 = 1'b1;
    r_s = rd_n3; rdy_s = rdy_n3;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort mem_rd", 32'(rd_n3 - r_s), 0);
    chk("abort pready", 32'(rdy_n3 - rdy_s), 0);
    xfer("after abort", vecs[13]);

    // reset while a write is on the memory bus
    xfer("pre-reset wr", mk(0, 1, 32'h40, 32'h55AA55AA, 4'hF, 32'h0, 0, 2, 1, 0, 4'hF, 10'h10));
    use3 = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    chk("cmd mem_wr before reset", 32'(m0_wr), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero0("async reset");
    psel = 1'b0; penable = 1'b0;
    w_s = wr_n0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("post-reset idle mem_wr", 32'(wr_n0 - w_s), 0);
    v = mk(0, 0, 32'h40, 32'h0, 4'h0, 32'h55AA55AA, 0, 3, 0, 1, 4'hF, 10'h10);
    v.alt_rdata = 32'hCAFEF00D;
    xfer("post-reset rd", v);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
